// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Word-addressed data RAM for a processor under test, with a
//               store log FIFO, a tohost completion mailbox and a watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int          DEPTH_WORDS     = 64,
    parameter int          LOG_DEPTH       = 8,
    parameter logic [31:0] TOHOST_ADDR     = 32'h64,
    parameter int          WATCHDOG_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        log_valid,
    input  logic        log_ready,
    output logic [31:0] log_addr,
    output logic [31:0] log_data,
    output logic        log_overflow,
    output logic        addr_err,
    output logic        done,
    output logic [31:0] done_value,
    output logic        timeout
);

    localparam int          c_idxW      = $clog2(DEPTH_WORDS);
    localparam int          c_ptrW      = $clog2(LOG_DEPTH);
    localparam int          c_cntW      = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [31:0] c_byteLimit = 32'(DEPTH_WORDS * 4);
    localparam logic [c_ptrW:0]   c_logFull = (c_ptrW + 1)'(LOG_DEPTH);
    localparam logic [c_cntW-1:0] c_wdLast  = c_cntW'(WATCHDOG_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN          = 2'd0,
        HALT_DONE    = 2'd1,
        HALT_TIMEOUT = 2'd2
    } wdState_t;

    // ------------------------------------------------------------------
    // Address decode and RAM
    // ------------------------------------------------------------------
    logic [31:0]       r_mem [DEPTH_WORDS];
    logic [c_idxW-1:0] w_wordIdx;
    logic              w_inRange;
    logic              w_aligned;
    logic              w_storeOk;
    logic              w_storeBad;
    logic              w_mailbox;

    assign w_wordIdx  = DataAdr[c_idxW+1:2];
    assign w_inRange  = (DataAdr < c_byteLimit);
    assign w_aligned  = (DataAdr[1:0] == 2'b00);
    assign w_storeOk  = MemWrite && w_inRange && w_aligned;
    assign w_storeBad = MemWrite && !(w_inRange && w_aligned);
    assign w_mailbox  = w_storeOk && (DataAdr == TOHOST_ADDR);

    assign ReadData = w_inRange ? r_mem[w_wordIdx] : 32'h0;

    // RAM contents deliberately survive reset so a program image persists.
    always_ff @(posedge clk) begin
        if (!reset && w_storeOk) begin
            r_mem[w_wordIdx] <= WriteData;
        end
    end

    // ------------------------------------------------------------------
    // Store log FIFO
    // ------------------------------------------------------------------
    logic [31:0]       r_logAddrMem [LOG_DEPTH];
    logic [31:0]       r_logDataMem [LOG_DEPTH];
    logic [c_ptrW-1:0] r_wrPtr;
    logic [c_ptrW-1:0] r_rdPtr;
    logic [c_ptrW:0]   r_count;
    logic              r_overflow;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_pushOk;
    logic              w_drop;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_logFull);
    assign w_pop    = !w_empty && log_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_pushOk = MemWrite && (!w_full || w_pop);
    assign w_drop   = MemWrite && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (!reset && w_pushOk) begin
            r_logAddrMem[r_wrPtr] <= DataAdr;
            r_logDataMem[r_wrPtr] <= WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pushOk) begin
                r_wrPtr <= r_wrPtr + c_ptrW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_ptrW'(1);
            end
            case ({w_pushOk, w_pop})
                2'b10:   r_count <= r_count + (c_ptrW + 1)'(1);
                2'b01:   r_count <= r_count - (c_ptrW + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign log_valid    = !w_empty;
    assign log_addr     = w_empty ? 32'h0 : r_logAddrMem[r_rdPtr];
    assign log_data     = w_empty ? 32'h0 : r_logDataMem[r_rdPtr];
    assign log_overflow = r_overflow;

    // ------------------------------------------------------------------
    // Sticky status flags and mailbox capture
    // ------------------------------------------------------------------
    logic        r_addrErr;
    logic        r_done;
    logic [31:0] r_doneValue;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addrErr   <= 1'b0;
            r_done      <= 1'b0;
            r_doneValue <= 32'h0;
        end else begin
            if (w_storeBad) begin
                r_addrErr <= 1'b1;
            end
            if (w_mailbox && !r_done) begin
                r_done      <= 1'b1;
                r_doneValue <= WriteData;
            end
        end
    end

    assign addr_err   = r_addrErr;
    assign done       = r_done;
    assign done_value = r_doneValue;

    // ------------------------------------------------------------------
    // Watchdog FSM
    // ------------------------------------------------------------------
    wdState_t          r_state;
    wdState_t          w_stateNext;
    logic [c_cntW-1:0] r_wdCount;
    logic [c_cntW-1:0] w_wdCountNext;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= RUN;
            r_wdCount <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_wdCount <= w_wdCountNext;
        end
    end

    // A mailbox store wins over an expiring counter in the same cycle.
    always_comb begin
        w_stateNext   = r_state;
        w_wdCountNext = r_wdCount;
        case (r_state)
            RUN: begin
                if (w_mailbox) begin
                    w_stateNext = HALT_DONE;
                end else if (r_wdCount == c_wdLast) begin
                    w_stateNext = HALT_TIMEOUT;
                end else begin
                    w_wdCountNext = r_wdCount + c_cntW'(1);
                end
            end
            HALT_DONE:    w_stateNext = HALT_DONE;
            HALT_TIMEOUT: w_stateNext = HALT_TIMEOUT;
            default:      w_stateNext = RUN;
        endcase
    end

    assign timeout = (r_state == HALT_TIMEOUT);

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Directed self-checking bench for data_mem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        log_valid;
    logic        log_ready;
    logic [31:0] log_addr;
    logic [31:0] log_data;
    logic        log_overflow;
    logic        addr_err;
    logic        done;
    logic [31:0] done_value;
    logic        timeout;

    int errors = 0;
    int checks = 0;

    data_mem_responder #(
        .DEPTH_WORDS    (64),
        .LOG_DEPTH      (8),
        .TOHOST_ADDR    (32'h64),
        .WATCHDOG_CYCLES(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .MemWrite    (MemWrite),
        .DataAdr     (DataAdr),
        .WriteData   (WriteData),
        .ReadData    (ReadData),
        .log_valid   (log_valid),
        .log_ready   (log_ready),
        .log_addr    (log_addr),
        .log_data    (log_data),
        .log_overflow(log_overflow),
        .addr_err    (addr_err),
        .done        (done),
        .done_value  (done_value),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        MemWrite  = 1'b0;
        log_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (log_valid !== 1'b0) begin errors++; $display("FAIL reset_log_valid: got %0b want 0", log_valid); end
        checks++; if (log_addr !== 32'h0) begin errors++; $display("FAIL reset_log_addr: got %h want 0", log_addr); end
        checks++; if (log_data !== 32'h0) begin errors++; $display("FAIL reset_log_data: got %h want 0", log_data); end
        checks++; if (log_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b want 0", log_overflow); end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err: got %0b want 0", addr_err); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
        checks++; if (done_value !== 32'h0) begin errors++; $display("FAIL reset_done_value: got %h want 0", done_value); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %0b want 0", timeout); end
    endtask

    task automatic test_read_write();
        do_reset();
        store(32'h30, 32'hA5A5_0001);
        MemWrite  = 1'b1;
        DataAdr   = 32'h30;
        WriteData = 32'h5A5A_0002;
        #1;
        checks++; if (ReadData !== 32'hA5A5_0001) begin errors++; $display("FAIL rw_same_cycle_old: got %h want a5a50001", ReadData); end
        tick();
        MemWrite = 1'b0;
        DataAdr  = 32'h33;
        #1;
        checks++; if (ReadData !== 32'h5A5A_0002) begin errors++; $display("FAIL rw_new_word_unaligned_read: got %h want 5a5a0002", ReadData); end
    endtask

    task automatic test_mailbox();
        do_reset();
        store(32'h64, 32'h7);
        #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL mbox_done: got %0b want 1", done); end
        checks++; if (done_value !== 32'h7) begin errors++; $display("FAIL mbox_done_value: got %h want 7", done_value); end
        checks++; if (ReadData !== 32'h7) begin errors++; $display("FAIL mbox_readdata: got %h want 7", ReadData); end
        checks++; if (log_valid !== 1'b1 || log_addr !== 32'h64 || log_data !== 32'h7) begin errors++; $display("FAIL mbox_log_entry: got v=%0b %h/%h want 1 64/7", log_valid, log_addr, log_data); end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL mbox_addr_err: got %0b want 0", addr_err); end
        store(32'h64, 32'h9);
        #1;
        checks++; if (done_value !== 32'h7) begin errors++; $display("FAIL mbox_value_held: got %h want 7", done_value); end
        checks++; if (ReadData !== 32'h9) begin errors++; $display("FAIL mbox_second_write: got %h want 9", ReadData); end
    endtask

    task automatic test_addr_err();
        logic [31:0] expA [3];
        logic [31:0] expD [3];
        expA[0] = 32'h102; expD[0] = 32'hDEAD;
        expA[1] = 32'h200; expD[1] = 32'hBEEF;
        expA[2] = 32'h6;   expD[2] = 32'h66;
        do_reset();
        store(32'h0, 32'hAAAA_5555);
        store(32'h4, 32'h4444_4444);
        #1;
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL err_clean_store: got %0b want 0", addr_err); end
        do_reset();
        store(expA[0], expD[0]);
        #1;
        checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL err_out_of_range: got %0b want 1", addr_err); end
        store(expA[1], expD[1]);
        store(expA[2], expD[2]);
        DataAdr = 32'h0;
        #1;
        checks++; if (ReadData !== 32'hAAAA_5555) begin errors++; $display("FAIL err_word0_kept: got %h want aaaa5555", ReadData); end
        DataAdr = 32'h4;
        #1;
        checks++; if (ReadData !== 32'h4444_4444) begin errors++; $display("FAIL err_misaligned_kept: got %h want 44444444", ReadData); end
        DataAdr = 32'h200;
        #1;
        checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL err_oor_read_zero: got %h want 0", ReadData); end
        log_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (log_valid !== 1'b1 || log_addr !== expA[i] || log_data !== expD[i]) begin errors++; $display("FAIL err_log_entry%0d: got v=%0b %h/%h want 1 %h/%h", i, log_valid, log_addr, log_data, expA[i], expD[i]); end
            tick();
        end
        checks++; if (log_valid !== 1'b0) begin errors++; $display("FAIL err_log_empty: got %0b want 0", log_valid); end
        log_ready = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 8; i++) store(32'(i * 4), 32'h100 + 32'(i));
        checks++; if (log_overflow !== 1'b0) begin errors++; $display("FAIL ovf_exactly_full: got %0b want 0", log_overflow); end
        store(32'h20, 32'h108);
        checks++; if (log_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b want 1", log_overflow); end
        log_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (log_valid !== 1'b1 || log_addr !== 32'(i * 4) || log_data !== 32'h100 + 32'(i)) begin errors++; $display("FAIL ovf_drain%0d: got v=%0b %h/%h want 1 %h/%h", i, log_valid, log_addr, log_data, 32'(i * 4), 32'h100 + 32'(i)); end
            tick();
        end
        checks++; if (log_valid !== 1'b0 || log_addr !== 32'h0) begin errors++; $display("FAIL ovf_drained_empty: got v=%0b addr=%h want 0 0", log_valid, log_addr); end
        checks++; if (log_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b want 1", log_overflow); end
        log_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 8; i++) store(32'h40 + 32'(i * 4), 32'h200 + 32'(i));
        log_ready = 1'b1;
        store(32'h80, 32'h2FF);
        log_ready = 1'b0;
        checks++; if (log_overflow !== 1'b0) begin errors++; $display("FAIL b2b_no_overflow: got %0b want 0", log_overflow); end
        log_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            checks++; if (log_addr !== 32'h40 + 32'(i * 4) || log_data !== 32'h200 + 32'(i)) begin errors++; $display("FAIL b2b_entry%0d: got %h/%h want %h/%h", i, log_addr, log_data, 32'h40 + 32'(i * 4), 32'h200 + 32'(i)); end
            tick();
        end
        checks++; if (log_valid !== 1'b1 || log_addr !== 32'h80 || log_data !== 32'h2FF) begin errors++; $display("FAIL b2b_appended: got v=%0b %h/%h want 1 80/2ff", log_valid, log_addr, log_data); end
        tick();
        checks++; if (log_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %0b want 0", log_valid); end
        store(32'h8, 32'h88);
        checks++; if (log_valid !== 1'b1 || log_addr !== 32'h8 || log_data !== 32'h88) begin errors++; $display("FAIL b2b_push_pop_empty: got v=%0b %h/%h want 1 8/88", log_valid, log_addr, log_data); end
        tick();
        checks++; if (log_valid !== 1'b0) begin errors++; $display("FAIL b2b_popped_after: got %0b want 0", log_valid); end
        log_ready = 1'b0;
    endtask

    task automatic test_watchdog();
        do_reset();
        for (int i = 0; i < 15; i++) tick();
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL wd_not_yet: got %0b want 0", timeout); end
        tick();
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL wd_expired: got %0b want 1", timeout); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL wd_no_done: got %0b want 0", done); end
        do_reset();
        for (int i = 0; i < 15; i++) tick();
        store(32'h64, 32'h55);
        checks++; if (done !== 1'b1 || done_value !== 32'h55) begin errors++; $display("FAIL wd_last_cycle_done: got %0b/%h want 1/55", done, done_value); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL wd_done_wins: got %0b want 0", timeout); end
        for (int i = 0; i < 20; i++) tick();
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL wd_halt_terminal: got %0b want 0", timeout); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        store(32'h10, 32'h1010);
        store(32'h14, 32'h1414);
        store(32'h64, 32'h77);
        store(32'h3, 32'h33);
        checks++; if (done !== 1'b1 || addr_err !== 1'b1 || log_valid !== 1'b1) begin errors++; $display("FAIL mid_setup: got done=%0b err=%0b v=%0b want 1 1 1", done, addr_err, log_valid); end
        reset     = 1'b1;
        MemWrite  = 1'b1;
        DataAdr   = 32'h10;
        WriteData = 32'hBAD;
        tick();
        MemWrite = 1'b0;
        reset    = 1'b0;
        checks++; if (log_valid !== 1'b0 || log_addr !== 32'h0 || log_data !== 32'h0) begin errors++; $display("FAIL mid_log_cleared: got v=%0b %h/%h want 0 0/0", log_valid, log_addr, log_data); end
        checks++; if (done !== 1'b0 || done_value !== 32'h0) begin errors++; $display("FAIL mid_done_cleared: got %0b/%h want 0/0", done, done_value); end
        checks++; if (addr_err !== 1'b0 || timeout !== 1'b0 || log_overflow !== 1'b0) begin errors++; $display("FAIL mid_flags_cleared: got err=%0b to=%0b ovf=%0b want 0 0 0", addr_err, timeout, log_overflow); end
        tick();
        checks++; if (log_valid !== 1'b0) begin errors++; $display("FAIL mid_no_log_in_reset: got %0b want 0", log_valid); end
        DataAdr = 32'h10;
        #1;
        checks++; if (ReadData !== 32'h1010) begin errors++; $display("FAIL mid_ram_kept_10: got %h want 1010", ReadData); end
        DataAdr = 32'h64;
        #1;
        checks++; if (ReadData !== 32'h77) begin errors++; $display("FAIL mid_ram_kept_64: got %h want 77", ReadData); end
    endtask

    initial begin
        reset     = 1'b1;
        MemWrite  = 1'b0;
        DataAdr   = 32'h0;
        WriteData = 32'h0;
        log_ready = 1'b0;
        test_reset();
        test_read_write();
        test_mailbox();
        test_addr_err();
        test_overflow();
        test_back_to_back();
        test_watchdog();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameters SHALL be: DEPTH_WORDS, 64, RAM size in 32-bit words (power of 2); LOG_DEPTH, 8, write-log FIFO entries (power of 2); TOHOST_ADDR, 32'h64, completion mailbox byte address; WATCHDOG_CYCLES, 1000, cycle limit before timeout.
REQ-002 Ports SHALL be, in order:
  clk          in   1   rising-edge clock
  reset        in   1   synchronous, active-high reset
  MemWrite     in   1   processor store strobe
  DataAdr      in   32  processor byte address
  WriteData    in   32  processor store data
  ReadData     out  32  load data to processor
  log_valid    out  1   write-log head entry present
  log_ready    in   1   bench accepts head entry
  log_addr     out  32  head entry address
  log_data     out  32  head entry data
  log_overflow out  1   sticky: a log entry was dropped
  addr_err     out  1   sticky: misaligned or out-of-range store
  done         out  1   sticky: mailbox written
  done_value   out  32  first value written to mailbox
  timeout      out  1   sticky: watchdog expired
REQ-003 The block SHALL use one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-004 Word index SHALL be DataAdr[log2(DEPTH_WORDS)+1:2]; address is in range when DataAdr < DEPTH_WORDS*4.
REQ-005 ReadData SHALL be combinational: mem[index] when in range, 32'h0 otherwise; DataAdr[1:0] ignored for reads.
REQ-006 On a rising edge with MemWrite=1, in range and DataAdr[1:0]=0, mem[index] SHALL take WriteData; a same-cycle read returns the old word.
REQ-007 A MemWrite with DataAdr[1:0]!=0 or out of range SHALL NOT modify RAM and SHALL set addr_err from the next cycle.
REQ-008 Every cycle with MemWrite=1, whether accepted or erroneous, SHALL push {DataAdr, WriteData} into the log FIFO.
REQ-009 log_valid=1 iff FIFO non-empty; log_addr/log_data SHALL show the head entry, 32'h0 when empty.
REQ-010 A pop SHALL occur on an edge where log_valid=1 and log_ready=1; log_ready while empty has no effect.
REQ-011 Push when full without a simultaneous pop SHALL drop the entry and set log_overflow; push and pop together when full SHALL both occur, occupancy unchanged.
REQ-012 Push and pop together when empty SHALL push only; the entry is visible the next cycle.
REQ-013 Pointers SHALL wrap modulo LOG_DEPTH; occupancy tracked with an extra pointer bit or counter, 0..LOG_DEPTH.
REQ-014 An accepted store to TOHOST_ADDR SHALL also write RAM; when done=0 it SHALL set done=1 and done_value=WriteData from the next cycle; later mailbox stores do not change done_value.
REQ-015 Watchdog states: RUN, HALT_DONE, HALT_TIMEOUT. RUN: counter increments each cycle from 0. Mailbox store -> HALT_DONE. Counter reaching WATCHDOG_CYCLES-1 with no mailbox store that cycle -> HALT_TIMEOUT, timeout=1 next cycle. Both same cycle -> HALT_DONE. Halt states are terminal until reset; counter holds.
REQ-016 Sticky flags SHALL clear only on reset.

Reset
REQ-017 While reset=1 at an edge: FIFO empty, log_valid=0, log_addr/log_data=0, log_overflow=0, addr_err=0, done=0, done_value=0, timeout=0, counter=0, state RUN.
REQ-018 Reset SHALL NOT clear RAM; MemWrite during a reset cycle SHALL NOT write RAM or log.
REQ-019 Reset mid-operation SHALL discard all log entries and flags immediately.

Verification
REQ-020 Store 0x7 to 0x64, then load 0x64 -> done=1, done_value=0x7 next cycle, ReadData=0x7, one log entry {0x64,0x7}.
REQ-021 Store to 0x102 and to 0x200 -> RAM unchanged, addr_err=1, two log entries, ReadData(0x200)=0.
REQ-022 Nine stores, log_ready=0 -> eight entries retained in order, log_overflow=1; drain with log_ready=1 -> eight pops then log_valid=0.
REQ-023 Full FIFO, store with log_ready=1 -> oldest popped, new entry appended, log_overflow stays 0.
REQ-024 No mailbox store, WATCHDOG_CYCLES=16 -> timeout=1 after exactly 16 cycles post-reset; mailbox store in cycle 15 instead -> done=1, timeout=0.
REQ-025 Reset asserted with four log entries and done=1 -> all outputs at reset values next cycle, RAM contents preserved.
